// File: rtl/pic_pkg.sv
// Shared constants and types for the synchronous 8259-style interrupt core.
// Register map, CTRL bit positions, ack FSM encoding.
package pic_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_IMR   = 2'd1;
  localparam logic [1:0] ADDR_VBASE = 2'd2;
  localparam logic [1:0] ADDR_EOI   = 2'd3;

  localparam logic [1:0] ADDR_RD_IRR    = 2'd0;
  localparam logic [1:0] ADDR_RD_IMR    = 2'd1;
  localparam logic [1:0] ADDR_RD_ISR    = 2'd2;
  localparam logic [1:0] ADDR_RD_STATUS = 2'd3;

  localparam int CTRL_LEVEL_BIT = 0;
  localparam int CTRL_AEOI_BIT  = 1;
  localparam int CTRL_ROT_BIT   = 2;
  localparam int CTRL_SMM_BIT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_ACK2 = 2'd2
  } ack_state_e;

  typedef struct packed {
    logic smm;
    logic rotate;
    logic auto_eoi;
    logic level_mode;
  } ctrl_t;

  // The specific-EOI flag lives in the top bit of the bus.
  function automatic int eoi_specific_bit(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority resolver: finds the highest-priority set bit starting at ptr.
// rank is the distance from ptr (0 = highest priority).
module pic_priority_resolver #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] rank
);

  int lvl;

  // Scan lowest priority first so the highest-priority hit is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    rank  = '0;
    lvl   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      lvl = int'(ptr) + k;
      if (lvl >= N) lvl = lvl - N;
      if (req[IDX_W'(lvl)]) begin
        valid = 1'b1;
        index = IDX_W'(lvl);
        rank  = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/pic_core_sync.sv
// Synchronous interrupt controller core: IRR/ISR/IMR, rotating priority, INTA FSM.
// Optional macro SPECIAL_MASK_EN adds CTRL bit3 special mask mode.
module pic_core_sync
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int DATA_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               chip_select_n,
  input  logic               read_enable_n,
  input  logic               write_enable_n,
  input  logic [1:0]         address,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_out_en,
  input  logic [NUM_IRQ-1:0] interrupt_request_pin,
  input  logic               interrupt_acknowledge_n,
  output logic               interrupt_to_cpu
);

  localparam int IDX_W    = $clog2(NUM_IRQ);
  localparam int EOI_SPEC = eoi_specific_bit(DATA_W);

  logic                    wr_s_q, wr_s_d, wr_prev_q, wr_prev_d;
  logic [1:0]              addr_s_q, addr_s_d;
  logic [DATA_W-1:0]       din_s_q, din_s_d;
  logic                    inta_s_q, inta_s_d, inta_prev_q, inta_prev_d;
  logic [NUM_IRQ-1:0]      pin_s_q, pin_s_d, pin_prev_q, pin_prev_d;

  logic [NUM_IRQ-1:0]      irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  ctrl_t                   ctrl_q, ctrl_d;
  logic [DATA_W-IDX_W-1:0] vbase_q, vbase_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d, winner_q, winner_d;
  logic                    spur_q, spur_d, int_q, int_d;
  ack_state_e              state_q, state_d;

  logic [NUM_IRQ-1:0]      irr_req, isr_nest;
  logic                    irr_vld, isr_vld, cand_vld;
  logic [IDX_W-1:0]        irr_idx, irr_rank, isr_idx, isr_rank;
  logic                    wr_commit, inta_fall, inta_rise;
  logic                    eoi_hit, irr_clr;
  logic [IDX_W-1:0]        eoi_lvl;
  logic [DATA_W-1:0]       rd_sel;

  function automatic logic [IDX_W-1:0] lvl_inc(input logic [IDX_W-1:0] l);
    return (int'(l) == NUM_IRQ - 1) ? '0 : l + 1'b1;
  endfunction

  // Special mask mode hides masked in-service levels from the nesting check.
  assign irr_req  = irr_q & ~imr_q;
  assign isr_nest = isr_q & ~(ctrl_q.smm ? imr_q : '0);

  pic_priority_resolver #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_irr_res (
    .req   (irr_req),
    .ptr   (ptr_q),
    .valid (irr_vld),
    .index (irr_idx),
    .rank  (irr_rank)
  );

  pic_priority_resolver #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_isr_res (
    .req   (isr_nest),
    .ptr   (ptr_q),
    .valid (isr_vld),
    .index (isr_idx),
    .rank  (isr_rank)
  );

  assign cand_vld  = irr_vld && (!isr_vld || (irr_rank < isr_rank));
  assign wr_commit = wr_s_q & ~wr_prev_q;
  assign inta_fall = inta_prev_q & ~inta_s_q;
  assign inta_rise = ~inta_prev_q & inta_s_q;

  always_comb begin
    wr_s_d      = ~chip_select_n & ~write_enable_n;
    wr_prev_d   = wr_s_q;
    addr_s_d    = address;
    din_s_d     = data_in;
    inta_s_d    = interrupt_acknowledge_n;
    inta_prev_d = inta_s_q;
    pin_s_d     = interrupt_request_pin;
    pin_prev_d  = pin_s_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_s_q      <= 1'b0;
      wr_prev_q   <= 1'b0;
      addr_s_q    <= '0;
      din_s_q     <= '0;
      inta_s_q    <= 1'b1;
      inta_prev_q <= 1'b1;
      pin_s_q     <= '0;
      pin_prev_q  <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '1;
      ctrl_q      <= '0;
      vbase_q     <= '0;
      ptr_q       <= '0;
      winner_q    <= '0;
      spur_q      <= 1'b0;
      int_q       <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      wr_s_q      <= wr_s_d;
      wr_prev_q   <= wr_prev_d;
      addr_s_q    <= addr_s_d;
      din_s_q     <= din_s_d;
      inta_s_q    <= inta_s_d;
      inta_prev_q <= inta_prev_d;
      pin_s_q     <= pin_s_d;
      pin_prev_q  <= pin_prev_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      ctrl_q      <= ctrl_d;
      vbase_q     <= vbase_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      spur_q      <= spur_d;
      int_q       <= int_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (inta_fall) state_d = ST_ACK1;
      ST_ACK1: if (inta_fall) state_d = ST_ACK2;
      ST_ACK2: if (inta_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irr_d    = irr_q;
    isr_d    = isr_q;
    imr_d    = imr_q;
    ctrl_d   = ctrl_q;
    vbase_d  = vbase_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    spur_d   = spur_q;
    eoi_hit  = 1'b0;
    eoi_lvl  = '0;
    irr_clr  = 1'b0;

    if (ctrl_q.level_mode) irr_d = pin_s_q;
    else                   irr_d = irr_q | (pin_s_q & ~pin_prev_q);

    if (wr_commit) begin
      case (addr_s_q)
        ADDR_CTRL: begin
          ctrl_d            = '0;
          ctrl_d.level_mode = din_s_q[CTRL_LEVEL_BIT];
          ctrl_d.auto_eoi   = din_s_q[CTRL_AEOI_BIT];
          ctrl_d.rotate     = din_s_q[CTRL_ROT_BIT];
`ifdef SPECIAL_MASK_EN
          ctrl_d.smm        = din_s_q[CTRL_SMM_BIT];
`else
          ctrl_d.smm        = 1'b0;
`endif
          irr_clr           = 1'b1;
        end
        ADDR_IMR:   imr_d   = din_s_q[NUM_IRQ-1:0];
        ADDR_VBASE: vbase_d = din_s_q[DATA_W-1:IDX_W];
        ADDR_EOI: begin
          // Non-specific EOI targets the top level of the nesting view of ISR.
          if (din_s_q[EOI_SPEC]) begin
            eoi_lvl = din_s_q[IDX_W-1:0];
            eoi_hit = (isr_q != '0) && (int'(eoi_lvl) < NUM_IRQ);
          end else begin
            eoi_lvl = isr_idx;
            eoi_hit = isr_vld;
          end
        end
        default: ;
      endcase
    end

    // An in-flight ack keeps its own ISR bit; rotation still takes effect.
    if (eoi_hit) begin
      if (!((state_q != ST_IDLE) && !spur_q && (eoi_lvl == winner_q)))
        isr_d[eoi_lvl] = 1'b0;
      if (ctrl_q.rotate) ptr_d = lvl_inc(eoi_lvl);
    end

    if ((state_q == ST_IDLE) && inta_fall) begin
      spur_d   = !cand_vld;
      winner_d = cand_vld ? irr_idx : IDX_W'(NUM_IRQ - 1);
      if (cand_vld) begin
        isr_d[irr_idx] = 1'b1;
        irr_d[irr_idx] = 1'b0;
      end
    end

    if ((state_q == ST_ACK2) && inta_rise && ctrl_q.auto_eoi && !spur_q) begin
      isr_d[winner_q] = 1'b0;
      if (ctrl_q.rotate) ptr_d = lvl_inc(winner_q);
    end

    if (irr_clr) irr_d = '0;

    int_d = cand_vld && (state_d == ST_IDLE);
  end

  always_comb begin
    rd_sel = '0;
    case (address)
      ADDR_RD_IRR: rd_sel[NUM_IRQ-1:0] = irr_q;
      ADDR_RD_IMR: rd_sel[NUM_IRQ-1:0] = imr_q;
      ADDR_RD_ISR: rd_sel[NUM_IRQ-1:0] = isr_q;
      default: begin
        rd_sel[0]   = int_q;
        rd_sel[2:1] = state_q;
      end
    endcase

    data_out    = '0;
    data_out_en = 1'b0;
    if (!reset) begin
      if ((state_q == ST_ACK2) && !interrupt_acknowledge_n) begin
        data_out_en = 1'b1;
        data_out    = {vbase_q, winner_q};
      end else if ((state_q == ST_IDLE) && !chip_select_n && !read_enable_n) begin
        data_out_en = 1'b1;
        data_out    = rd_sel;
      end
    end
  end

  assign interrupt_to_cpu = int_q;

endmodule

// File: tb/tb_pic_core_sync.sv
// Directed bench for pic_core_sync (NUM_IRQ=8, DATA_W=8).
module tb_pic_core_sync;

  logic       clock = 1'b0;
  logic       reset;
  logic       chip_select_n, read_enable_n, write_enable_n;
  logic [1:0] address;
  logic [7:0] data_in, data_out;
  logic       data_out_en;
  logic [7:0] interrupt_request_pin;
  logic       interrupt_acknowledge_n;
  logic       interrupt_to_cpu;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] vec;
  logic       ven;

  always #5 clock = ~clock;

  pic_core_sync #(.NUM_IRQ(8), .DATA_W(8)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .chip_select_n           (chip_select_n),
    .read_enable_n           (read_enable_n),
    .write_enable_n          (write_enable_n),
    .address                 (address),
    .data_in                 (data_in),
    .data_out                (data_out),
    .data_out_en             (data_out_en),
    .interrupt_request_pin   (interrupt_request_pin),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .interrupt_to_cpu        (interrupt_to_cpu)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    address = a; data_in = d; chip_select_n = 1'b0; write_enable_n = 1'b0;
    tick(2);
    chip_select_n = 1'b1; write_enable_n = 1'b1;
    tick(2);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    address = a; chip_select_n = 1'b0; read_enable_n = 1'b0;
    #1;
    check(tag, data_out, exp);
    chip_select_n = 1'b1; read_enable_n = 1'b1;
    #1;
  endtask

  task automatic inta_seq(output logic [7:0] v, output logic en);
    interrupt_acknowledge_n = 1'b0; tick(3);
    interrupt_acknowledge_n = 1'b1; tick(3);
    interrupt_acknowledge_n = 1'b0; tick(2);
    v = data_out; en = data_out_en;
    tick(1);
    interrupt_acknowledge_n = 1'b1; tick(3);
  endtask

  task automatic pulse_pins(input logic [7:0] p);
    interrupt_request_pin = p; tick(3);
    interrupt_request_pin = '0;
  endtask

  initial begin
    reset = 1'b1; chip_select_n = 1'b1; read_enable_n = 1'b1; write_enable_n = 1'b1;
    address = '0; data_in = '0; interrupt_request_pin = '0; interrupt_acknowledge_n = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_int", {7'd0, interrupt_to_cpu}, 8'h00);
    check("rst_en", {7'd0, data_out_en}, 8'h00);
    check("rst_dout", data_out, 8'h00);
    rd_chk("rst_irr", 2'd0, 8'h00);
    rd_chk("rst_imr", 2'd1, 8'hFF);
    rd_chk("rst_isr", 2'd2, 8'h00);
    rd_chk("rst_status", 2'd3, 8'h00);

    // Edge mode, single request on level 3.
    bus_write(2'd0, 8'h00);
    bus_write(2'd2, 8'h20);
    bus_write(2'd1, 8'hF7);
    interrupt_request_pin = 8'h08;
    tick(2);
    check("t1_int_early", {7'd0, interrupt_to_cpu}, 8'h00);
    tick(1);
    check("t1_int", {7'd0, interrupt_to_cpu}, 8'h01);
    interrupt_request_pin = '0;
    rd_chk("t1_irr_pend", 2'd0, 8'h08);
    inta_seq(vec, ven);
    check("t1_vec", vec, 8'h23);
    check("t1_vec_en", {7'd0, ven}, 8'h01);
    rd_chk("t1_isr", 2'd2, 8'h08);
    rd_chk("t1_irr", 2'd0, 8'h00);
    check("t1_int_off", {7'd0, interrupt_to_cpu}, 8'h00);
    bus_write(2'd3, 8'h00);
    rd_chk("t1_isr_eoi", 2'd2, 8'h00);

    // Two simultaneous requests, fully nested.
    bus_write(2'd1, 8'h00);
    pulse_pins(8'h24);
    check("t2_int", {7'd0, interrupt_to_cpu}, 8'h01);
    inta_seq(vec, ven);
    check("t2_vec_a", vec, 8'h22);
    rd_chk("t2_isr_a", 2'd2, 8'h04);
    rd_chk("t2_irr_a", 2'd0, 8'h20);
    check("t2_nested", {7'd0, interrupt_to_cpu}, 8'h00);
    bus_write(2'd3, 8'h00);
    check("t2_int_b", {7'd0, interrupt_to_cpu}, 8'h01);
    inta_seq(vec, ven);
    check("t2_vec_b", vec, 8'h25);
    rd_chk("t2_isr_b", 2'd2, 8'h20);
    bus_write(2'd3, 8'h00);

    // Rotation on EOI: ptr moves to 1 after servicing level 0.
    bus_write(2'd0, 8'h04);
    pulse_pins(8'h01);
    inta_seq(vec, ven);
    check("t3_vec_a", vec, 8'h20);
    bus_write(2'd3, 8'h00);
    pulse_pins(8'h03);
    inta_seq(vec, ven);
    check("t3_vec_b", vec, 8'h21);
    rd_chk("t3_isr", 2'd2, 8'h02);
    rd_chk("t3_irr", 2'd0, 8'h01);
    bus_write(2'd3, 8'h81);
    rd_chk("t3_isr_spec", 2'd2, 8'h00);

    // Auto-EOI: ISR clears on the ACK2 INTA rising edge.
    bus_write(2'd0, 8'h02);
    pulse_pins(8'h10);
    inta_seq(vec, ven);
    check("t4_vec", vec, 8'h24);
    rd_chk("t4_isr", 2'd2, 8'h00);
    rd_chk("t4_irr", 2'd0, 8'h00);

    // Spurious acknowledge.
    inta_seq(vec, ven);
    check("t5_vec", vec, 8'h27);
    rd_chk("t5_isr", 2'd2, 8'h00);

    // Level mode: IRR follows the pin.
    bus_write(2'd0, 8'h01);
    interrupt_request_pin = 8'h80;
    tick(2);
    rd_chk("t6_irr_hi", 2'd0, 8'h80);
    interrupt_request_pin = '0;
    tick(2);
    rd_chk("t6_irr_lo", 2'd0, 8'h00);

    // Reset while in ACK2.
    interrupt_acknowledge_n = 1'b0; tick(3);
    interrupt_acknowledge_n = 1'b1; tick(3);
    interrupt_acknowledge_n = 1'b0; tick(2);
    check("t7_en_ack2", {7'd0, data_out_en}, 8'h01);
    reset = 1'b1;
    interrupt_acknowledge_n = 1'b1;
    tick(1);
    check("t7_en_rst", {7'd0, data_out_en}, 8'h00);
    check("t7_int_rst", {7'd0, interrupt_to_cpu}, 8'h00);
    reset = 1'b0;
    tick(1);
    rd_chk("t7_imr", 2'd1, 8'hFF);
    rd_chk("t7_status", 2'd3, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pic_core_sync.md
Name: pic_core_sync

Overview:
Clocked, parametrised successor of the 8259-style interrupt controller.
- Merges IRR, ISR, priority resolver, mask and INTA sequencing into one synchronous core on `clock`.
- Supports NUM_IRQ request lines, edge or level triggering, rotating priority and auto-EOI.
- Sits between the CPU bus strobes and the peripheral request pins; it replaces the ad-hoc combinational bus mux with registered, edge-detected strobes.

Parameters:
- NUM_IRQ, 8, number of request lines (2..DATA_W).
- DATA_W, 8, bus width; NUM_IRQ <= DATA_W.
- IDX_W, $clog2(NUM_IRQ), localparam, width of the level index.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high.
- chip_select_n  in  1  bus chip select.
- read_enable_n  in  1  bus read strobe.
- write_enable_n  in  1  bus write strobe.
- address  in  2  register select.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read/vector data.
- data_out_en  out  1  tri-state enable for top-level bus driver.
- interrupt_request_pin  in  NUM_IRQ  peripheral requests.
- interrupt_acknowledge_n  in  1  CPU INTA.
- interrupt_to_cpu  out  1  registered INT.

Behaviour:
- Reset values:
  - IRR=0, ISR=0, IMR=all 1s, CTRL=0, VECTOR_BASE=0, priority pointer=0, FSM=IDLE.
  - interrupt_to_cpu=0, data_out=0, data_out_en=0.
- Strobe sampling:
  - Strobes and pins are sampled each clock.
  - A write commits on the cycle after the first sample with chip_select_n=0 and write_enable_n=0 (falling-edge detect); one commit per strobe.
- Registers, write side:
  - addr0 CTRL: bit0 level_mode, bit1 auto_eoi, bit2 rotate_on_eoi.
  - addr1 IMR.
  - addr2 VECTOR_BASE (low IDX_W bits ignored).
  - addr3 EOI: bit DATA_W-1 selects specific; low IDX_W bits give the level.
- Registers, read side (combinational; data_out_en=1 while chip_select_n=0, read_enable_n=0 and FSM=IDLE):
  - addr0 IRR, addr1 IMR, addr2 ISR.
  - addr3 status: bit0 interrupt_to_cpu, bits2:1 FSM state.
- IRR:
  - Edge mode sets a bit on a sampled 0->1 pin transition.
  - Level mode makes the bit follow the pin.
  - The bit clears when its level is acknowledged in ACK1.
  - Writing CTRL clears IRR.
- Priority:
  - Highest priority is level `ptr`, descending cyclically through (ptr+1) mod NUM_IRQ.
  - Candidate is the highest unmasked IRR bit whose priority is strictly above the highest ISR bit (fully nested).
  - interrupt_to_cpu <= candidate_valid, one cycle latency; it is deasserted in ACK1/ACK2.
- FSM IDLE/ACK1/ACK2:
  - IDLE -> ACK1 on INTA falling edge: latch winner, set ISR bit, clear IRR bit.
  - ACK1 -> ACK2 on second INTA falling edge: data_out={VECTOR_BASE[DATA_W-1:IDX_W], winner}, data_out_en=1 while INTA low.
  - ACK2 -> IDLE on INTA rising edge. If auto_eoi, clear the ISR bit on that edge, and advance ptr to winner+1 if rotate_on_eoi.
- Spurious ack: no candidate at the first INTA -> vector level NUM_IRQ-1, ISR untouched.
- EOI:
  - Non-specific clears the highest-priority ISR bit.
  - Specific clears the named bit.
  - With rotate_on_eoi, ptr=(cleared level+1) mod NUM_IRQ.
  - EOI with ISR=0 has no effect.
- Simultaneous events:
  - A pin edge on the same cycle as its ACK1 clear: the clear wins and the edge is lost (documented).
  - EOI write in ACK1/ACK2: applied; the winner's ISR bit is protected that cycle.
- Reset mid-ack returns to IDLE with all state at reset values.

Optional Feature:
- SPECIAL_MASK_EN: CTRL bit3 = special_mask_mode.
  - When set, ISR bits whose IMR bit is 1 are excluded from the nesting comparison, so lower levels can interrupt.
  - Without the macro, bit3 is not stored, reads 0, and nesting always uses the full ISR.

Decomposition:
- Package pic_pkg:
  - Register address constants.
  - CTRL bit positions.
  - EOI specific-bit position.
  - Ack FSM state enum (2 bits).
- Sub-module pic_priority_resolver: combinational.
  - Inputs: request vector, ptr.
  - Outputs: valid, index, rotated-priority rank (used for both IRR winner and highest ISR).

Test Plan:
- Edge, IMR=0xFF->0xF7, pulse pin3 -> interrupt_to_cpu=1 one cycle after sampling; two INTA pulses with VECTOR_BASE=0x20 -> data_out=0x23, ISR=0x08, IRR=0.
- Pins 2 and 5 simultaneously, IMR=0 -> vector level 2 first; non-specific EOI -> level 5 requested; ISR=0x20 after second ack.
- rotate_on_eoi=1, service level 0, EOI -> ptr=1; then pins 0 and 1 both set -> level 1 wins.
- auto_eoi=1, ack level 4 -> ISR=0 after INTA rising edge of ACK2; no EOI write needed.
- INTA sequence with no request -> vector level 7 (NUM_IRQ=8), ISR stays 0.
- Reset asserted in ACK2 -> FSM IDLE, data_out_en=0, IMR=0xFF next cycle.
